// File: rtl/posit_div_encode_pkg.sv
// rtl/posit_div_encode_pkg.sv - posit_div_pkg: default widths, special posit constants, stage-1 flag payload
package posit_div_pkg;

    localparam int PD_N  = 8;
    localparam int PD_ES = 4;
    localparam int PD_RS = $clog2(PD_N);

    localparam logic [PD_N-1:0] PD_NAR    = {1'b1, {(PD_N-1){1'b0}}};
    localparam logic [PD_N-1:0] PD_MAXPOS = {1'b0, {(PD_N-1){1'b1}}};
    localparam logic [PD_N-1:0] PD_MINPOS = {{(PD_N-1){1'b0}}, 1'b1};

    // Width-independent part of the stage-1 payload; the kept magnitude bits ride alongside.
    typedef struct packed {
        logic sign;
        logic inf;
        logic zero;
        logic sat;
        logic guard;
        logic sticky;
    } s1_flags_t;

endpackage

// File: rtl/posit_div_encode_if.sv
// rtl/posit_div_encode_if.sv - divide-result in / encoded posit out handshake bundle
interface posit_div_encode_if #(
    parameter int N  = 8,
    parameter int ES = 4,
    parameter int RS = $clog2(N)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*N-1:0]        Div_Mant_N;
    logic [RS+ES+4:0]      Total_EO;
    logic [RS+4:0]         R_O;
    logic                  Sign;
    logic                  inf;
    logic                  zero;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          Result;

    modport master (
        output in_valid, Div_Mant_N, Total_EO, R_O, Sign, inf, zero, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, Div_Mant_N, Total_EO, R_O, Sign, inf, zero, out_ready,
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/posit_div_encode_round.sv
// rtl/posit_div_encode_round.sv - posit_round: round (RNE when POSIT_DIV_RNE_EN, else truncate), sign-apply, specials
module posit_round
    import posit_div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-2:0] mag,
    input  s1_flags_t    flags,
    output logic [N-1:0] posit
);

    logic         up;
    logic [N-1:0] sum;
    logic [N-2:0] rmag;

`ifndef POSIT_DIV_RNE_EN
    logic unused_rnd;
    assign unused_rnd = &{1'b0, flags.guard, flags.sticky};
`endif

    always_comb begin
        up = 1'b0;
`ifdef POSIT_DIV_RNE_EN
        up = flags.guard & (flags.sticky | mag[0]) & ~flags.sat;
`endif
        // Carry ripples from fraction into exponent and regime naturally; only the top needs clamping.
        sum  = {1'b0, mag} + {{(N-1){1'b0}}, up};
        rmag = sum[N-1] ? {(N-1){1'b1}} : sum[N-2:0];
        if (rmag == '0) begin
            rmag = {{(N-2){1'b0}}, 1'b1};
        end
        if (flags.inf) begin
            posit = {1'b1, {(N-1){1'b0}}};
        end else if (flags.zero) begin
            posit = '0;
        end else if (flags.sign) begin
            posit = -{1'b0, rmag};
        end else begin
            posit = {1'b0, rmag};
        end
    end

endmodule

// File: rtl/posit_div_encode.sv
// rtl/posit_div_encode.sv - 2-stage posit encoder for divider results; POSIT_DIV_RNE_EN selects round-to-nearest-even
module posit_div_encode
    import posit_div_pkg::*;
#(
    parameter int N  = PD_N,
    parameter int ES = PD_ES,
    parameter int RS = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    posit_div_encode_if.slave bus
);

    localparam int W = N + ES + 2*N - 1;

    logic              s1_valid;
    logic              s2_valid;
    logic [N-2:0]      s1_mag;
    s1_flags_t         s1_flags;
    logic [N-1:0]      result_q;
    logic [N-1:0]      rounded;
    logic              s2_adv;

    logic              pos;
    logic              sat;
    logic [RS+4:0]     shamt;
    logic [N-1:0]      prefix;
    logic [W-1:0]      str;
    logic [N-2:0]      mag_c;
    s1_flags_t         flags_c;
    logic              unused_in;

    assign s2_adv        = ~s2_valid | bus.out_ready;
    assign bus.in_ready  = ~s1_valid | s2_adv;
    assign bus.out_valid = s2_valid;
    assign bus.Result    = result_q;
    assign unused_in     = &{1'b0, bus.Total_EO, bus.Div_Mant_N[2*N-1]};

    // Prefix is "1..10" or "0..01" at full width; the left shift trims it to R_O run bits plus terminator.
    always_comb begin
        pos    = ~bus.Total_EO[RS+ES+4];
        sat    = bus.R_O >= (RS+5)'(N-1);
        shamt  = (RS+5)'(N-1) - bus.R_O;
        prefix = pos ? {{(N-1){1'b1}}, 1'b0} : {{(N-1){1'b0}}, 1'b1};
        str    = {prefix, bus.Total_EO[ES-1:0], bus.Div_Mant_N[2*N-2:0]} << shamt;

        flags_c.sign = bus.Sign;
        flags_c.inf  = bus.inf;
        flags_c.zero = bus.zero;
        flags_c.sat  = sat;
        if (sat) begin
            mag_c          = pos ? {(N-1){1'b1}} : {{(N-2){1'b0}}, 1'b1};
            flags_c.guard  = 1'b0;
            flags_c.sticky = 1'b0;
        end else begin
            mag_c          = str[W-1 -: N-1];
            flags_c.guard  = str[W-N];
            flags_c.sticky = |str[W-N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            result_q <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result_q <= rounded;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            s1_mag   <= mag_c;
            s1_flags <= flags_c;
        end
    end

    posit_round #(.N(N)) u_round (
        .mag   (s1_mag),
        .flags (s1_flags),
        .posit (rounded)
    );

endmodule

// File: doc/posit_div_encode.md
POSIT_DIV_ENCODE -- requirements
Module: posit_div_encode

Interface
REQ-001 SHALL have parameter N, default 8, posit width in bits.
REQ-002 SHALL have parameter ES, default 4, exponent field width.
REQ-003 SHALL have parameter RS, default $clog2(N), regime-count width base.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream divide result valid.
REQ-007 SHALL have port in_ready  output  1  block can accept input this cycle.
REQ-008 SHALL have port Div_Mant_N  input  2N  normalised quotient mantissa, MSB = hidden 1.
REQ-009 SHALL have port Total_EO  input  RS+ES+5  signed total scale (k*2^ES + e).
REQ-010 SHALL have port R_O  input  RS+5  regime run length.
REQ-011 SHALL have port Sign, inf, zero  input  1 each  result sign, NaR flag, zero flag.
REQ-012 SHALL have port out_valid  output  1  Result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts Result.
REQ-014 SHALL have port Result  output  N  encoded posit.

Function
REQ-015 SHALL be a 2-stage valid/ready pipeline; input accepted on in_valid&in_ready appears on Result exactly 2 cycles later when out_ready held high.
REQ-016 SHALL drive in_ready = !s1_valid | (!s2_valid | out_ready) (stage advances when next stage empty or draining); no combinational path in_valid->in_ready.
REQ-017 SHALL hold Result and out_valid stable while out_valid & !out_ready; no payload lost or duplicated under any stall pattern.
REQ-018 Stage 1 SHALL build the unrounded string: regime = R_O ones then 0 if Total_EO >= 0, else R_O zeros then 1; then exponent field Total_EO[ES-1:0]; then Div_Mant_N[2N-2:0]; left-aligned into N-1 kept bits plus guard and sticky (OR of remainder).
REQ-019 Stage 2 SHALL round (per REQ-030), then two's-complement the N-1-bit magnitude with leading 0 if Sign=1.
REQ-020 Rounding carry SHALL propagate through fraction, exponent and regime fields without separate correction.
REQ-021 R_O >= N-1 with Total_EO >= 0 SHALL saturate magnitude to maxpos (0 followed by N-1 ones); with Total_EO < 0 to minpos (N-1 zeros then 1); no rounding applied.
REQ-022 Rounding SHALL never produce magnitude 0 from nonzero input nor overflow past maxpos.
REQ-023 inf=1 SHALL give Result = 1 followed by N-1 zeros (NaR), overriding zero and Sign.
REQ-024 zero=1, inf=0 SHALL give Result = 0.
REQ-025 Flags SHALL travel with their payload through both stages.

Reset
REQ-026 On reset, s1_valid, s2_valid and out_valid SHALL be 0 and Result SHALL be 0 the following cycle.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-028 Reset mid-operation SHALL discard all in-flight payloads; none emerge afterwards.
REQ-029 Payload registers other than Result need no reset.

Configuration
REQ-030 Macro POSIT_DIV_RNE_EN defined: round-to-nearest-even (up when guard & (sticky | kept LSB)); undefined: truncation (guard and sticky ignored); saturation and special cases identical in both.

Structure
REQ-031 Package posit_div_pkg SHALL hold N/ES/RS defaults, NaR/maxpos/minpos constants and the stage-1 payload struct type.
REQ-032 Rounding/negation SHALL be one combinational sub-module, posit_round, instantiated in stage 2.

Verification (N=8, ES=4)
REQ-033 Total_EO=0, R_O=1, Div_Mant_N=16'h8000, Sign=0 -> Result 8'h40 after 2 cycles; Sign=1 -> 8'hC0.
REQ-034 Total_EO=-1, R_O=1, Div_Mant_N=16'h8000 -> 8'h3E.
REQ-035 Total_EO=0, R_O=1, Div_Mant_N=16'hE000 -> 8'h42 with POSIT_DIV_RNE_EN, 8'h41 without.
REQ-036 R_O=7, Total_EO=+96 -> 8'h7F; R_O=7, Total_EO=-112 -> 8'h01; inf=1,zero=1 -> 8'h80; zero=1 -> 8'h00.
REQ-037 Back-to-back 10 inputs, out_ready toggled pseudo-randomly -> 10 Results in order, none lost/duplicated, Result stable during stalls.
REQ-038 reset asserted with both stages full -> out_valid 0 next cycle, no stale Result after release.
